regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have parameter NRP, default 2, read port count; legal range 1..4.
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (1 = on, 0 = off).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rstn, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have port i_raddr, input, NRP*5, read addresses; port k uses bits [5k+4:5k].
REQ-008 SHALL have port o_rdata, output, NRP*XLEN, read data; port k uses bits [XLEN*k+XLEN-1:XLEN*k].
REQ-009 SHALL have port o_rbusy, output, NRP, scoreboard busy bit of each read address.
REQ-010 SHALL have ports i_wb_wvalid/i_wb_waddr/i_wb_wdata, input, 1/5/XLEN, primary (ALU writeback) write.
REQ-011 SHALL have ports i_ld_wvalid/i_ld_waddr/i_ld_wdata, input, 1/5/XLEN, secondary (load return) write.
REQ-012 SHALL have ports i_sb_set/i_sb_addr, input, 1/5, mark a register pending for a load.
REQ-013 SHALL have port o_busy_vec, output, NREGS, registered scoreboard vector.
REQ-014 SHALL have port o_busy_cnt, output, $clog2(NREGS+1), registered count of set busy bits.
REQ-015 SHALL have port o_collide, output, 1, registered one-cycle flag for a same-address dual write.

Function
REQ-016 SHALL return 0 on any read of x0 and never report x0 busy.
REQ-017 SHALL ignore writes and i_sb_set to x0.
REQ-018 SHALL treat addresses >= NREGS as illegal: reads return 0 with busy 0; writes and sb_set are ignored.
REQ-019 SHALL commit each valid, legal write on the next rising edge of clk.
REQ-020 SHALL, when both writes target the same legal non-zero address in one cycle, commit i_wb_wdata only and assert o_collide for exactly the following cycle.
REQ-021 SHALL provide combinational reads, meaning zero-cycle latency from i_raddr to o_rdata.
REQ-022 SHALL, with BYPASS=1, return the write data on a read whose address equals a same-cycle valid write; wb has priority over ld.
REQ-023 SHALL, with BYPASS=0, return the pre-edge stored value for such a read.
REQ-024 SHALL set busy[i_sb_addr] at the next edge when i_sb_set=1.
REQ-025 SHALL clear busy[i_ld_waddr] at the next edge when i_ld_wvalid=1; a wb write SHALL NOT change busy.
REQ-026 SHALL keep a register busy when i_sb_set and an ld write hit the same address in one cycle (set wins).
REQ-027 SHALL, with BYPASS=1, drive o_rbusy[k]=0 when port k reads the address of a same-cycle ld write and there is no same-cycle sb_set to that address; with BYPASS=0, o_rbusy SHALL reflect only the registered vector.
REQ-028 SHALL update o_busy_cnt in the same edge as o_busy_vec, so that it always equals popcount(o_busy_vec); the count SHALL neither wrap nor saturate, since its maximum is NREGS-1.
REQ-029 SHALL treat an sb_set to a register that is already busy as a no-op, with o_busy_cnt unchanged.

Reset
REQ-030 SHALL, while rstn=0 at an edge, clear all registers, o_busy_vec, o_busy_cnt and o_collide to 0, overriding all concurrent writes and sets.
REQ-031 SHALL discard any pending load on a mid-operation reset; after reset release, a later ld write to that address SHALL write data and leave busy at 0.

Verification
REQ-032 Write wb x5=0xDEADBEEF, then read x5 on port 0 next cycle -> o_rdata[0]=0xDEADBEEF; write x0=0x1234 -> read x0 = 0.
REQ-033 With BYPASS=1, wb x7=0xA5A5A5A5 and read x7 on port 1 in the same cycle -> 0xA5A5A5A5 the same cycle; with BYPASS=0 -> old value 0.
REQ-034 Dual write: wb x3=0x11 and ld x3=0x22 in the same cycle -> x3=0x11, o_collide=1 for one cycle, then 0.
REQ-035 sb_set x4, x9 on consecutive cycles -> o_busy_cnt=2; ld write x4=0x55 -> busy[4]=0, cnt=1, and o_rbusy for x4 drops the same cycle when BYPASS=1.
REQ-036 sb_set x6 and ld write x6 in the same cycle -> busy[6] stays 1 and x6 = load data.
REQ-037 With NREGS=16, write x20=0xFF and sb_set x20 -> no state change and read x20 = 0; then assert rstn=0 with busy nonzero for one cycle -> all registers and outputs 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register file port bundle: read ports, two write ports, scoreboard set.
// master drives requests, slave (the register file) returns data/status.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
);
  logic [NRP*5-1:0]            i_raddr;
  logic [NRP*XLEN-1:0]         o_rdata;
  logic [NRP-1:0]              o_rbusy;
  logic                        i_wb_wvalid;
  logic [4:0]                  i_wb_waddr;
  logic [XLEN-1:0]             i_wb_wdata;
  logic                        i_ld_wvalid;
  logic [4:0]                  i_ld_waddr;
  logic [XLEN-1:0]             i_ld_wdata;
  logic                        i_sb_set;
  logic [4:0]                  i_sb_addr;
  logic [NREGS-1:0]            o_busy_vec;
  logic [$clog2(NREGS+1)-1:0]  o_busy_cnt;
  logic                        o_collide;

  modport master (
    output i_raddr, i_wb_wvalid, i_wb_waddr, i_wb_wdata,
    output i_ld_wvalid, i_ld_waddr, i_ld_wdata,
    output i_sb_set, i_sb_addr,
    input  o_rdata, o_rbusy, o_busy_vec, o_busy_cnt, o_collide
  );

  modport slave (
    input  i_raddr, i_wb_wvalid, i_wb_waddr, i_wb_wdata,
    input  i_ld_wvalid, i_ld_waddr, i_ld_wdata,
    input  i_sb_set, i_sb_addr,
    output o_rdata, o_rbusy, o_busy_vec, o_busy_cnt, o_collide
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with load scoreboard,
// wb/ld write ports and optional write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS+1);
  localparam logic [5:0] NR = 6'(NREGS);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             collide_q;

  function automatic logic legal(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NR);
  endfunction

  logic wb_ok, ld_ok, sb_ok, collide, ld_wr;
  logic [AW-1:0] wb_idx, ld_idx, sb_idx;

  assign wb_ok   = bus.i_wb_wvalid && legal(bus.i_wb_waddr);
  assign ld_ok   = bus.i_ld_wvalid && legal(bus.i_ld_waddr);
  assign sb_ok   = bus.i_sb_set && legal(bus.i_sb_addr);
  assign collide = wb_ok && ld_ok &&
                   (bus.i_wb_waddr == bus.i_ld_waddr);
  assign ld_wr   = ld_ok && !collide;

  assign wb_idx = bus.i_wb_waddr[AW-1:0];
  assign ld_idx = bus.i_ld_waddr[AW-1:0];
  assign sb_idx = bus.i_sb_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (ld_wr) regs[ld_idx] <= bus.i_ld_wdata;
      if (wb_ok) regs[wb_idx] <= bus.i_wb_wdata;
    end
  end

  // A returning load clears its bit; a same-cycle set re-arms it.
  always_comb begin
    busy_d = busy_q;
    if (ld_ok) busy_d[ld_idx] = 1'b0;
    if (sb_ok) busy_d[sb_idx] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_d = cnt_d + CW'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q    <= '0;
      cnt_q     <= '0;
      collide_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      collide_q <= collide;
    end
  end

  assign bus.o_busy_vec = busy_q;
  assign bus.o_busy_cnt = cnt_q;
  assign bus.o_collide  = collide_q;

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [4:0]    a;
    logic [AW-1:0] idx;
    logic          ok, hit_wb, hit_ld, hit_sb;

    assign a      = bus.i_raddr[5*k +: 5];
    assign idx    = a[AW-1:0];
    assign ok     = legal(a);
    assign hit_wb = BP && wb_ok && (bus.i_wb_waddr == a);
    assign hit_ld = BP && ld_ok && (bus.i_ld_waddr == a);
    assign hit_sb = sb_ok && (bus.i_sb_addr == a);

    assign bus.o_rdata[XLEN*k +: XLEN] =
      !ok    ? '0 :
      hit_wb ? bus.i_wb_wdata :
      hit_ld ? bus.i_ld_wdata :
               regs[idx];

    assign bus.o_rbusy[k] = ok && busy_q[idx] && !(hit_ld && !hit_sb);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (default,
// no forwarding, 16-register) share one directed stimulus stream.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  raddr = '0;
  logic        wbv = 0, ldv = 0, sbs = 0;
  logic [4:0]  wba = '0, lda = '0, sba = '0;
  logic [31:0] wbd = '0, ldd = '0;

  regfile_mp_if              if0 ();
  regfile_mp_if              if1 ();
  regfile_mp_if #(.NREGS(16)) if2 ();

  assign if0.i_raddr = raddr; assign if1.i_raddr = raddr;
  assign if2.i_raddr = raddr;
  assign if0.i_wb_wvalid = wbv; assign if1.i_wb_wvalid = wbv;
  assign if2.i_wb_wvalid = wbv;
  assign if0.i_wb_waddr = wba; assign if1.i_wb_waddr = wba;
  assign if2.i_wb_waddr = wba;
  assign if0.i_wb_wdata = wbd; assign if1.i_wb_wdata = wbd;
  assign if2.i_wb_wdata = wbd;
  assign if0.i_ld_wvalid = ldv; assign if1.i_ld_wvalid = ldv;
  assign if2.i_ld_wvalid = ldv;
  assign if0.i_ld_waddr = lda; assign if1.i_ld_waddr = lda;
  assign if2.i_ld_waddr = lda;
  assign if0.i_ld_wdata = ldd; assign if1.i_ld_wdata = ldd;
  assign if2.i_ld_wdata = ldd;
  assign if0.i_sb_set = sbs; assign if1.i_sb_set = sbs;
  assign if2.i_sb_set = sbs;
  assign if0.i_sb_addr = sba; assign if1.i_sb_addr = sba;
  assign if2.i_sb_addr = sba;

  regfile_mp u0 (.clk(clk), .rstn(rstn), .bus(if0));
  regfile_mp #(.BYPASS(0)) u1 (.clk(clk), .rstn(rstn), .bus(if1));
  regfile_mp #(.NREGS(16)) u2 (.clk(clk), .rstn(rstn), .bus(if2));

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:  return if0.o_rdata[31:0];
      1:  return if0.o_rdata[63:32];
      2:  return 32'(if0.o_rbusy);
      3:  return 32'(if0.o_busy_vec);
      4:  return 32'(if0.o_busy_cnt);
      5:  return 32'(if0.o_collide);
      10: return if1.o_rdata[31:0];
      11: return if1.o_rdata[63:32];
      12: return 32'(if1.o_rbusy);
      20: return if2.o_rdata[31:0];
      22: return 32'(if2.o_rbusy);
      23: return 32'(if2.o_busy_vec);
      24: return 32'(if2.o_busy_cnt);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        logic [31:0] act;
        act = actual(q[i].sel);
        checks++;
        if (act !== q[i].exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)",
                   q[i].name, act, q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(input int d, input int sel,
                      input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc = cyc + d; c.sel = sel; c.exp = exp; c.name = name;
    q.push_back(c);
  endtask

  task automatic step(input logic [4:0] r0, input logic [4:0] r1);
    @(posedge clk);
    #1;
    wbv = 0; ldv = 0; sbs = 0;
    raddr = {r1, r0};
  endtask

  initial begin
    step(5'd5, 5'd3);
    rstn = 0;
    wbv = 1; wba = 5'd5; wbd = 32'h1111;
    sbs = 1; sba = 5'd3;
    push(1, 3, 32'h0, "rst_busy_vec");
    push(1, 4, 32'h0, "rst_busy_cnt");
    push(1, 5, 32'h0, "rst_collide");

    step(5'd5, 5'd3);
    rstn = 1;
    push(0, 0, 32'h0, "rst_x5");
    push(0, 2, 32'h0, "rst_rbusy");

    step(5'd5, 5'd0);
    wbv = 1; wba = 5'd5; wbd = 32'hDEADBEEF;
    push(0, 0, 32'hDEADBEEF, "byp_x5");
    push(0, 10, 32'h0, "nobyp_x5_old");

    step(5'd5, 5'd0);
    wbv = 1; wba = 5'd0; wbd = 32'h1234;
    push(0, 0, 32'hDEADBEEF, "rd_x5");
    push(0, 10, 32'hDEADBEEF, "nobyp_rd_x5");
    push(0, 1, 32'h0, "x0_write_byp");

    step(5'd5, 5'd0);
    push(0, 1, 32'h0, "x0_read");

    step(5'd0, 5'd7);
    wbv = 1; wba = 5'd7; wbd = 32'hA5A5A5A5;
    push(0, 1, 32'hA5A5A5A5, "byp_x7");
    push(0, 11, 32'h0, "nobyp_x7_old");

    step(5'd3, 5'd0);
    wbv = 1; wba = 5'd3; wbd = 32'h11;
    ldv = 1; lda = 5'd3; ldd = 32'h22;
    push(0, 0, 32'h11, "dual_byp_wb_prio");
    push(0, 10, 32'h0, "nobyp_x3_old");
    push(0, 5, 32'h0, "collide_pre");

    step(5'd3, 5'd0);
    push(0, 0, 32'h11, "dual_x3");
    push(0, 10, 32'h11, "nobyp_dual_x3");
    push(0, 5, 32'h1, "collide_set");
    push(1, 5, 32'h0, "collide_clear");

    step(5'd0, 5'd0);
    sbs = 1; sba = 5'd4;
    push(1, 4, 32'd1, "cnt_after_x4");

    step(5'd4, 5'd9);
    sbs = 1; sba = 5'd9;
    push(0, 2, 32'h1, "rbusy_x4_only");
    push(1, 4, 32'd2, "cnt_two");
    push(1, 3, 32'h0000_0210, "vec_x4_x9");

    step(5'd4, 5'd9);
    ldv = 1; lda = 5'd4; ldd = 32'h55;
    push(0, 2, 32'h2, "rbusy_ld_drop");
    push(0, 12, 32'h3, "nobyp_rbusy");
    push(0, 0, 32'h55, "ld_byp_x4");
    push(1, 4, 32'd1, "cnt_after_ld");
    push(1, 3, 32'h0000_0200, "vec_after_ld");

    step(5'd6, 5'd9);
    sbs = 1; sba = 5'd6;
    ldv = 1; lda = 5'd6; ldd = 32'h66;
    push(0, 2, 32'h2, "rbusy_set_ld");
    push(0, 0, 32'h66, "set_ld_byp");
    push(1, 3, 32'h0000_0240, "vec_set_wins");
    push(1, 4, 32'd2, "cnt_set_wins");

    step(5'd6, 5'd9);
    push(0, 0, 32'h66, "x6_ld_data");
    push(0, 2, 32'h3, "rbusy_x6_x9");

    step(5'd6, 5'd9);
    sbs = 1; sba = 5'd9;
    push(1, 4, 32'd2, "cnt_set_noop");

    step(5'd20, 5'd20);
    wbv = 1; wba = 5'd20; wbd = 32'hFF;
    sbs = 1; sba = 5'd20;
    push(0, 20, 32'h0, "e_x20_byp");
    push(0, 22, 32'h0, "e_x20_rbusy");
    push(1, 23, 32'h0000_0240, "e_vec");
    push(1, 24, 32'd2, "e_cnt");

    step(5'd20, 5'd20);
    push(0, 20, 32'h0, "e_x20_read");

    step(5'd5, 5'd9);
    rstn = 0;
    wbv = 1; wba = 5'd5; wbd = 32'h77;
    sbs = 1; sba = 5'd8;
    push(1, 3, 32'h0, "rst2_vec");
    push(1, 4, 32'h0, "rst2_cnt");
    push(1, 23, 32'h0, "e_rst2_vec");
    push(1, 24, 32'h0, "e_rst2_cnt");

    step(5'd5, 5'd9);
    rstn = 1;
    push(0, 0, 32'h0, "rst2_x5");
    push(0, 1, 32'h0, "rst2_x9");
    push(0, 20, 32'h0, "e_rst2_x5");
    push(0, 2, 32'h0, "rst2_rbusy");

    step(5'd9, 5'd0);
    ldv = 1; lda = 5'd9; ldd = 32'h99;
    push(0, 0, 32'h99, "stale_ld_byp");
    push(0, 10, 32'h0, "nobyp_stale_old");
    push(1, 3, 32'h0, "stale_ld_vec");
    push(1, 4, 32'h0, "stale_ld_cnt");

    step(5'd9, 5'd0);
    push(0, 10, 32'h99, "stale_ld_data");
    push(0, 2, 32'h0, "stale_ld_rbusy");

    step(5'd9, 5'd5);
    #1;
    checks++;
    if (if0.o_rdata[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL end_x9: got %h", if0.o_rdata[31:0]);
    end
    checks++;
    if (if1.o_rdata[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL end_nobyp_x9: got %h", if1.o_rdata[31:0]);
    end
    checks++;
    if (if0.o_rdata[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL end_x5: got %h", if0.o_rdata[63:32]);
    end
    checks++;
    if (if0.o_busy_cnt !== '0) begin
      errors++;
      $display("FAIL end_cnt: got %h", if0.o_busy_cnt);
    end
    checks++;
    if (if0.o_collide !== 1'b0) begin
      errors++;
      $display("FAIL end_collide: got %b", if0.o_collide);
    end
    checks++;
    if (if0.o_rbusy !== 2'b00) begin
      errors++;
      $display("FAIL end_rbusy: got %b", if0.o_rbusy);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    foreach (q[i]) begin
      errors++;
      $display("FAIL %s: never compared, expected %h", q[i].name, q[i].exp);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
